// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers.
// Holds stage state enum, MAX_REQ bound and rr_pick.
package arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

    // Round-robin pick over the first n requesters.
    // Scan starts just after 'last' and wraps; returns one-hot winner,
    // or all zeros when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 last,
        input int                 n
    );
        logic [MAX_REQ-1:0] onehot;
        logic               found;
        int                 idx;
        onehot = '0;
        found  = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = last + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k <= n && !found && valid[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
// Ports: valid, last_grant in; grant_onehot, grant_idx out.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        grant_onehot = NUM_REQ'(rr_pick(MAX_REQ'(valid),
                                        int'(last_grant),
                                        NUM_REQ));
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin valid/ready arbiter feeding one registered output stage.
// Ports: clk, reset (async active-low), input_valid/ready/data per
// requester, output_valid/ready/data/id. Optional ARB_LOCK_EN adds
// input_lock to pin the grant for atomic sequences.
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       input_valid,
    output logic [NUM_REQ-1:0]       input_ready,
    input  logic [NUM_REQ*WIDTH-1:0] input_data,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       input_lock,
`endif
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [WIDTH-1:0]         output_data,
    output logic [ID_W-1:0]          output_id
);

    stage_state_t         state;
    stage_state_t         state_d;
    logic [ID_W-1:0]      last_grant;
    logic [NUM_REQ-1:0]   rr_oh;
    logic [ID_W-1:0]      rr_idx;
    logic [NUM_REQ-1:0]   sel_oh;
    logic [ID_W-1:0]      sel_idx;
    logic                 can_load;
    logic                 insert;

`ifdef ARB_LOCK_EN
    logic                 pinned;
    logic [ID_W-1:0]      pin_id;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid        (input_valid),
        .last_grant   (last_grant),
        .grant_onehot (rr_oh),
        .grant_idx    (rr_idx)
    );

    // A pinned grant holds even when the owner drops valid,
    // so other requesters cannot slip into an atomic sequence.
    always_comb begin
        sel_oh  = rr_oh;
        sel_idx = rr_idx;
`ifdef ARB_LOCK_EN
        if (pinned) begin
            sel_oh          = '0;
            sel_oh[pin_id]  = 1'b1;
            sel_idx         = pin_id;
        end
`endif
    end

    assign output_valid = (state == FULL);
    assign can_load     = (state == EMPTY) || output_ready;

    // Ready is forced low while reset is held.
    assign input_ready = (reset && can_load) ? sel_oh : '0;
    assign insert      = |(input_valid & input_ready);

    always_comb begin
        state_d = state;
        unique case (state)
            EMPTY: begin
                if (insert) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!insert && output_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_d;
        end
    end

    // Priority only rotates on an accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            output_data <= '0;
            output_id   <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
        end else if (insert) begin
            output_data <= input_data[int'(sel_idx)*WIDTH +: WIDTH];
            output_id   <= sel_idx;
            last_grant  <= sel_idx;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pinned <= 1'b0;
            pin_id <= '0;
        end else if (insert) begin
            pinned <= input_lock[sel_idx];
            pin_id <= sel_idx;
        end
    end
`endif

endmodule
